// File: rtl/speaker_scheduler_pkg.sv
// Shared constants, FSM encodings and source codes for speaker_scheduler.
// The optional snooze feature is selected with SPEAKER_SCHEDULER_SNOOZE_EN.
package speaker_scheduler_pkg;

   localparam int unsigned SEC_PER_HOUR    = 3600;
   localparam int unsigned SEC_PER_DAY     = 86400;
   localparam int unsigned CHIME_START     = SEC_PER_HOUR - 8;
   localparam int unsigned CHIME_LAST_STEP = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHIME  = 3'd1,
      ST_ALARM  = 3'd2,
      ST_SNOOZE = 3'd3,
      ST_TIMER  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_CHIME = 2'd1,
      SRC_ALARM = 2'd2,
      SRC_TIMER = 2'd3
   } src_e;

   function automatic logic [11:0] sec_of_hour(input logic [16:0] sec);
      return 12'(sec % 17'(SEC_PER_HOUR));
   endfunction

   // SNOOZE deliberately reports no owner: the speaker is released while waiting.
   function automatic logic [1:0] state_src(input state_e st);
      src_e src;
      case (st)
         ST_CHIME: src = SRC_CHIME;
         ST_ALARM: src = SRC_ALARM;
         ST_TIMER: src = SRC_TIMER;
         default:  src = SRC_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/speaker_scheduler_tone_gen.sv
// Free-running 16-bit tone counter; exposes two bit-selects as square-wave tones.
module tone_gen
   import speaker_scheduler_pkg::*;
#(
   parameter int LO_BIT = 15,
   parameter int HI_BIT = 14
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tone_lo,
   output logic o_tone_hi
);

   logic [15:0] r_cnt;

   // tone counter, wraps naturally
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_tone_lo = r_cnt[LO_BIT];
   assign o_tone_hi = r_cnt[HI_BIT];

endmodule

// File: rtl/speaker_scheduler.sv
// Arbitrates chime / alarm / timer onto one speaker with fixed priority ALARM > TIMER > CHIME.
// Define SPEAKER_SCHEDULER_SNOOZE_EN to build the SNOOZE state and honour the snooze input.
module speaker_scheduler
   import speaker_scheduler_pkg::*;
#(
   parameter int TONE_LO_BIT = 15,
   parameter int TONE_HI_BIT = 14,
   parameter int ALARM_LEN_S = 60,
   parameter int SNOOZE_S    = 300,
   parameter int TIMER_LEN_S = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sec_tick,
   input  logic [16:0] cur_sec,
   input  logic        chime_en,
   input  logic        alarm_en,
   input  logic        alarm_set,
   input  logic [16:0] alarm_time_in,
   input  logic        snooze,
   input  logic        dismiss,
   input  logic        timer_done,
   output logic        speaker,
   output logic [1:0]  active,
   output logic [16:0] alarm_time
);

   localparam int STEP_MAX_A = (ALARM_LEN_S > TIMER_LEN_S) ? ALARM_LEN_S : TIMER_LEN_S;
   localparam int STEP_MAX_B = (STEP_MAX_A > SNOOZE_S) ? STEP_MAX_A : SNOOZE_S;
   localparam int STEP_MAX   = (STEP_MAX_B > 9) ? STEP_MAX_B : 9;
   localparam int STEP_W     = $clog2(STEP_MAX + 1);

   state_e              r_state;
   state_e              w_next;
   logic [STEP_W-1:0]   r_step;
   logic                r_speaker;
   logic [1:0]          r_active;
   logic [16:0]         r_alarm_time;
   logic                w_chime_req;
   logic                w_alarm_req;
   logic                w_timer_req;
   logic                w_lo_en;
   logic                w_hi_en;
   logic                w_tone_lo;
   logic                w_tone_hi;

   tone_gen #(
      .LO_BIT(TONE_LO_BIT),
      .HI_BIT(TONE_HI_BIT)
   ) u_tone_gen (
      .i_clk    (clk),
      .i_rst    (rst),
      .o_tone_lo(w_tone_lo),
      .o_tone_hi(w_tone_hi)
   );

`ifndef SPEAKER_SCHEDULER_SNOOZE_EN
   logic w_unused_snooze;
   assign w_unused_snooze = snooze;
`endif

   assign w_chime_req = sec_tick && chime_en && (sec_of_hour(cur_sec) == 12'(CHIME_START));
   assign w_alarm_req = sec_tick && alarm_en && (cur_sec == r_alarm_time);
   assign w_timer_req = timer_done;

   // next-state selection: cancels first, then preemption, then step timeouts
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_alarm_req)      w_next = ST_ALARM;
            else if (w_timer_req) w_next = ST_TIMER;
            else if (w_chime_req) w_next = ST_CHIME;
            else                  w_next = ST_IDLE;
         end
         ST_CHIME: begin
            if (dismiss || !chime_en) w_next = ST_IDLE;
            else if (w_alarm_req)     w_next = ST_ALARM;
            else if (w_timer_req)     w_next = ST_TIMER;
            else if (sec_tick && r_step == STEP_W'(CHIME_LAST_STEP)) w_next = ST_IDLE;
            else                      w_next = ST_CHIME;
         end
         ST_ALARM: begin
            if (dismiss || !alarm_en) w_next = ST_IDLE;
`ifdef SPEAKER_SCHEDULER_SNOOZE_EN
            else if (snooze)          w_next = ST_SNOOZE;
`endif
            else if (sec_tick && r_step == STEP_W'(ALARM_LEN_S - 1)) w_next = ST_IDLE;
            else                      w_next = ST_ALARM;
         end
`ifdef SPEAKER_SCHEDULER_SNOOZE_EN
         ST_SNOOZE: begin
            if (dismiss || !alarm_en) w_next = ST_IDLE;
            else if (w_alarm_req)     w_next = ST_ALARM;
            else if (w_timer_req)     w_next = ST_TIMER;
            else if (sec_tick && r_step == STEP_W'(SNOOZE_S - 1)) w_next = ST_ALARM;
            else                      w_next = ST_SNOOZE;
         end
`endif
         ST_TIMER: begin
            if (dismiss)          w_next = ST_IDLE;
            else if (w_alarm_req) w_next = ST_ALARM;
            else if (sec_tick && r_step == STEP_W'(TIMER_LEN_S - 1)) w_next = ST_IDLE;
            else                  w_next = ST_TIMER;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // tone gating derived from the current state and step
   always_comb begin
      w_lo_en = 1'b0;
      w_hi_en = 1'b0;
      case (r_state)
         ST_CHIME: begin
            if (r_step == STEP_W'(CHIME_LAST_STEP)) w_hi_en = 1'b1;
            else                                    w_lo_en = ~r_step[0];
         end
         ST_ALARM: w_lo_en = ~r_step[0];
         ST_TIMER: w_hi_en = 1'b1;
         default: begin
            w_lo_en = 1'b0;
            w_hi_en = 1'b0;
         end
      endcase
   end

   // state, step counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_step    <= '0;
         r_active  <= 2'd0;
         r_speaker <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_active  <= state_src(w_next);
         r_speaker <= (w_lo_en & w_tone_lo) | (w_hi_en & w_tone_hi);
         if (w_next != r_state)                  r_step <= '0;
         else if (sec_tick && r_state != ST_IDLE) r_step <= r_step + STEP_W'(1);
         else                                    r_step <= r_step;
      end
   end

   // alarm time store; out-of-range loads are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm_time <= 17'd0;
      end else if (alarm_set && (alarm_time_in < 17'(SEC_PER_DAY))) begin
         r_alarm_time <= alarm_time_in;
      end else begin
         r_alarm_time <= r_alarm_time;
      end
   end

   assign speaker    = r_speaker;
   assign active     = r_active;
   assign alarm_time = r_alarm_time;

endmodule
